// File: rtl/commit_trace_buffer.sv
// Retirement-trace monitor: timestamps WB/memory events into a FIFO,
// keeps cycle/inst/drop counters and a run watchdog.
module commit_trace_buffer #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 32,
  parameter int WATCHDOG = 100000,
  localparam int REC_W   = CNT_W + 4 + REG_AW + 3 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_en,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] reg_dest,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [REC_W-1:0]  rec_data,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow,
  output logic              done,
  output logic              timeout
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] P_ONE = (PW+1)'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} state_t;

  state_t           state, state_nx;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr, level;
  logic             run, ev, halt_ev, expire;
  logic             empty, full, pop, push, drop;
  logic [DATA_W-1:0] mdata;
  logic [REC_W-1:0] rec;

  assign run     = (state == RUN) && trace_en;
  assign ev      = run && (reg_write | mem_read | mem_write | halt);
  assign halt_ev = ev && halt;
  assign expire  = run && !halt_ev && (WATCHDOG != 0) &&
                   (cycle_cnt == WD_LAST);

  assign level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && rec_ready;
  // A full FIFO still takes the record when the head leaves this cycle.
  assign push  = ev && (!full || pop);
  assign drop  = ev && full && !pop;

  assign mdata = mem_write ? mem_wdata : mem_rdata;
  assign rec = {cycle_cnt, halt, mem_write, mem_read, reg_write,
                reg_dest, reg_data, mem_addr, mdata};

  assign rec_valid = !empty;
  assign rec_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign done      = state == DONE;
  assign timeout   = state == TIMEOUT;

  always_comb begin
    state_nx = state;
    if (trace_en) begin
      case (state)
        RUN: begin
          if (halt_ev)     state_nx = DRAIN;
          else if (expire) state_nx = TIMEOUT;
        end
        DRAIN: begin
          if (empty || (pop && level == P_ONE)) state_nx = DONE;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      if (run && !expire) cycle_cnt <= cycle_cnt + C_ONE;
      if (ev && (halt | reg_write | mem_write))
        inst_cnt <= inst_cnt + C_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (~&drop_cnt) drop_cnt <= drop_cnt + C_ONE;
      end
    end
  end
endmodule
